mem_wb_stage: RTL and testbench

MEM_WB_STAGE -- requirements
Module: mem_wb_stage

---
 rtl/mem_wb_stage_pkg.sv | 26 ++
 rtl/mem_wb_stage_data_memory.sv | 39 +++
 rtl/mem_wb_stage.sv | 91 +++++++++
 tb/tb_mem_wb_stage.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/mem_wb_stage_pkg.sv
// Shared pipeline definitions: datapath widths, default memory depth,
// the MEM/WB register payload and the alignment-fault predicate.
package mem_wb_stage_pkg;

  localparam int DATA_W     = 32;
  localparam int REG_W      = 5;
  localparam int ADDR_W_DEF = 8;

  // Everything the MEM/WB register carries apart from the load data,
  // which lives in the data memory's registered read port.
  typedef struct packed {
    logic              reg_write;
    logic              mem_to_reg;
    logic [REG_W-1:0]  rd;
    logic [DATA_W-1:0] alu_result;
  } memwb_ctrl_t;

  // A memory access is misaligned when it touches memory and the byte
  // offset within the 32-bit word is non-zero.
  function automatic logic is_misaligned(input logic       mem_read,
                                         input logic       mem_write,
                                         input logic [1:0] byte_off);
    return (mem_read || mem_write) && (byte_off != 2'b00);
  endfunction

endpackage

// File: rtl/mem_wb_stage_data_memory.sv
// Word-addressed data memory: synchronous write, registered read.
// The read register doubles as the ReadData field of the MEM/WB register,
// so it has its own clear (bubble/reset) and enable (hold) controls.
module data_memory
  import mem_wb_stage_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              i_clr,
  input  logic              i_re,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [0:(1<<ADDR_W)-1];
  logic [DATA_W-1:0] r_rdata;

  // Array write; contents are never cleared.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_addr] <= i_wdata;
    end
  end

  // Registered read: sees the pre-write word on a same-address write.
  always_ff @(posedge clk) begin
    if (i_clr) begin
      r_rdata <= '0;
    end else if (i_re) begin
      r_rdata <= r_mem[i_addr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/mem_wb_stage.sv
// MEM stage plus MEM/WB pipeline register. Owns the write-enable gating,
// the hold/bubble behaviour and the sticky misalignment fault record.
module mem_wb_stage
  import mem_wb_stage_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] ALUResult_In,
  input  logic [DATA_W-1:0] Rt_In,
  input  logic [REG_W-1:0]  rd_In,
  input  logic              MemRead_In,
  input  logic              MemWrite_In,
  input  logic              RegWrite_In,
  input  logic              MemToReg_In,
  input  logic              stall_In,
  input  logic              flush_In,
  output logic [DATA_W-1:0] ReadData_Out,
  output logic [DATA_W-1:0] ALUResult_Out,
  output logic [REG_W-1:0]  rd_Out,
  output logic              RegWrite_Out,
  output logic              MemToReg_Out,
  output logic [DATA_W-1:0] WriteBackData_Out,
  output logic              misalign_Out,
  output logic [DATA_W-1:0] fault_addr_Out
);

  memwb_ctrl_t       r_ctrl;
  logic              r_misalign;
  logic [DATA_W-1:0] r_fault_addr;

  logic              w_advance;
  logic              w_bubble;
  logic              w_misalign;
  logic              w_fault;
  logic              w_we;
  logic [ADDR_W-1:0] w_word_addr;

  // Upper address bits are dropped so accesses wrap modulo memory size.
  assign w_word_addr = ALUResult_In[ADDR_W+1:2];
  assign w_bubble    = rst || flush_In;
  assign w_advance   = !rst && !flush_In && !stall_In;
  assign w_misalign  = is_misaligned(MemRead_In, MemWrite_In, ALUResult_In[1:0]);
  assign w_fault     = w_advance && w_misalign;
  assign w_we        = w_advance && MemWrite_In && !w_misalign;

  data_memory #(.ADDR_W(ADDR_W)) u_dmem (
    .clk     (clk),
    .i_clr   (w_bubble),
    .i_re    (w_advance),
    .i_we    (w_we),
    .i_addr  (w_word_addr),
    .i_wdata (Rt_In),
    .o_rdata (ReadData_Out)
  );

  // MEM/WB control/result fields: bubble on reset/flush, hold on stall.
  always_ff @(posedge clk) begin
    if (w_bubble) begin
      r_ctrl <= '0;
    end else if (w_advance) begin
      r_ctrl.reg_write  <= RegWrite_In && !w_misalign;
      r_ctrl.mem_to_reg <= MemToReg_In;
      r_ctrl.rd         <= rd_In;
      r_ctrl.alu_result <= ALUResult_In;
    end
  end

  // Sticky fault flag; the address is latched only for the first fault.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_misalign   <= 1'b0;
      r_fault_addr <= '0;
    end else if (w_fault) begin
      r_misalign <= 1'b1;
      if (!r_misalign) begin
        r_fault_addr <= ALUResult_In;
      end
    end
  end

  assign ALUResult_Out     = r_ctrl.alu_result;
  assign rd_Out            = r_ctrl.rd;
  assign RegWrite_Out      = r_ctrl.reg_write;
  assign MemToReg_Out      = r_ctrl.mem_to_reg;
  assign misalign_Out      = r_misalign;
  assign fault_addr_Out    = r_fault_addr;
  assign WriteBackData_Out = r_ctrl.mem_to_reg ? ReadData_Out : r_ctrl.alu_result;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed plus randomized bench for mem_wb_stage against a word-array
// reference model of the MEM/WB behaviour.
module tb_mem_wb_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] ALUResult_In, Rt_In;
  logic [4:0]  rd_In;
  logic        MemRead_In, MemWrite_In, RegWrite_In, MemToReg_In;
  logic        stall_In, flush_In;
  logic [31:0] ReadData_Out, ALUResult_Out, WriteBackData_Out, fault_addr_Out;
  logic [4:0]  rd_Out;
  logic        RegWrite_Out, MemToReg_Out, misalign_Out;

  int checks   = 0;
  int failures = 0;

  // Reference state
  logic [31:0] m_mem [256];
  bit          m_ok  [256];
  logic [31:0] e_rdata, e_alu, e_fa;
  logic [4:0]  e_rd;
  logic        e_rw, e_m2r, e_mis;
  bit          e_rdata_ok;

  // clock / reset block
  always #5 clk = ~clk;

  mem_wb_stage #(.ADDR_W(8)) dut (
    .clk(clk), .rst(rst),
    .ALUResult_In(ALUResult_In), .Rt_In(Rt_In), .rd_In(rd_In),
    .MemRead_In(MemRead_In), .MemWrite_In(MemWrite_In),
    .RegWrite_In(RegWrite_In), .MemToReg_In(MemToReg_In),
    .stall_In(stall_In), .flush_In(flush_In),
    .ReadData_Out(ReadData_Out), .ALUResult_Out(ALUResult_Out),
    .rd_Out(rd_Out), .RegWrite_Out(RegWrite_Out), .MemToReg_Out(MemToReg_Out),
    .WriteBackData_Out(WriteBackData_Out),
    .misalign_Out(misalign_Out), .fault_addr_Out(fault_addr_Out)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock of the reference behaviour, applied to the current inputs.
  task automatic model_step();
    int  idx;
    bit  mis;
    idx = int'((ALUResult_In >> 2) % 256);
    mis = (MemRead_In || MemWrite_In) && (ALUResult_In % 4 != 0);
    if (rst) begin
      e_rw = 0; e_m2r = 0; e_rd = 0; e_alu = 0; e_rdata = 0; e_rdata_ok = 1;
      e_mis = 0; e_fa = 0;
    end else if (flush_In) begin
      e_rw = 0; e_m2r = 0; e_rd = 0; e_alu = 0; e_rdata = 0; e_rdata_ok = 1;
    end else if (!stall_In) begin
      e_rdata    = m_mem[idx];
      e_rdata_ok = m_ok[idx];
      if (MemWrite_In && !mis) begin
        m_mem[idx] = Rt_In;
        m_ok[idx]  = 1;
      end
      e_alu = ALUResult_In;
      e_rd  = rd_In;
      e_m2r = MemToReg_In;
      e_rw  = RegWrite_In && !mis;
      if (mis) begin
        if (!e_mis) e_fa = ALUResult_In;
        e_mis = 1;
      end
    end
  endtask

  task automatic check_all();
    chk("alu",      ALUResult_Out, e_alu);
    chk("rd",       {27'd0, rd_Out}, {27'd0, e_rd});
    chk("regwrite", {31'd0, RegWrite_Out}, {31'd0, e_rw});
    chk("memtoreg", {31'd0, MemToReg_Out}, {31'd0, e_m2r});
    chk("misalign", {31'd0, misalign_Out}, {31'd0, e_mis});
    chk("faddr",    fault_addr_Out, e_fa);
    if (e_rdata_ok) chk("rdata", ReadData_Out, e_rdata);
    if (!e_m2r || e_rdata_ok) chk("wbdata", WriteBackData_Out, e_m2r ? e_rdata : e_alu);
  endtask

  // driver: apply inputs, clock once, update model, check after the edge
  task automatic cyc(input logic r, input logic w, input logic rw, input logic m2r,
                     input logic st, input logic fl, input logic rs,
                     input logic [31:0] a, input logic [31:0] d, input logic [4:0] rdv);
    MemRead_In = r; MemWrite_In = w; RegWrite_In = rw; MemToReg_In = m2r;
    stall_In = st; flush_In = fl; rst = rs;
    ALUResult_In = a; Rt_In = d; rd_In = rdv;
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  initial begin
    logic [31:0] saved;
    for (int i = 0; i < 256; i++) begin m_mem[i] = '0; m_ok[i] = 0; end
    e_rdata = 0; e_alu = 0; e_fa = 0; e_rd = 0; e_rw = 0; e_m2r = 0; e_mis = 0; e_rdata_ok = 1;

    // reset state
    cyc(0, 0, 0, 0, 0, 0, 1, 32'h0, 32'h0, 5'd0);
    chk("reset_wb", WriteBackData_Out, 32'h0);
    cyc(0, 0, 1, 0, 1, 0, 1, 32'h3, 32'h0, 5'd7);
    chk("reset_over_stall_rd", {27'd0, rd_Out}, 32'h0);

    // preload every word
    for (int i = 0; i < 256; i++)
      cyc(0, 1, 0, 0, 0, 0, 0, 32'(i * 4), $urandom, 5'd0);

    // store then load 0x10
    cyc(0, 1, 0, 0, 0, 0, 0, 32'h10, 32'hDEADBEEF, 5'd0);
    cyc(1, 0, 1, 1, 0, 0, 0, 32'h10, 32'h0, 5'd5);
    chk("v030_rdata", ReadData_Out, 32'hDEADBEEF);
    chk("v030_wb", WriteBackData_Out, 32'hDEADBEEF);
    chk("v030_rd", {27'd0, rd_Out}, 32'd5);
    chk("v030_rw", {31'd0, RegWrite_Out}, 32'd1);

    // stalled store to 0x14 does not land, fields hold
    saved = m_mem[5];
    for (int i = 0; i < 3; i++) begin
      cyc(0, 1, 1, 0, 1, 0, 0, 32'h14, 32'h11111111, 5'd9);
      chk("v031_hold_rd", {27'd0, rd_Out}, 32'd5);
      chk("v031_hold_rdata", ReadData_Out, 32'hDEADBEEF);
    end
    cyc(1, 0, 1, 1, 0, 0, 0, 32'h14, 32'h0, 5'd6);
    chk("v031_old", ReadData_Out, saved);

    // flush with stall gives a bubble
    cyc(1, 0, 1, 1, 1, 1, 0, 32'h14, 32'h0, 5'd6);
    chk("v032_rw", {31'd0, RegWrite_Out}, 32'd0);
    chk("v032_rd", {27'd0, rd_Out}, 32'd0);
    chk("v032_wb", WriteBackData_Out, 32'd0);

    // misaligned store then misaligned load
    cyc(0, 0, 0, 0, 0, 0, 1, 32'h0, 32'h0, 5'd0);
    saved = m_mem[8];
    cyc(0, 1, 0, 0, 0, 0, 0, 32'h22, 32'hCAFEF00D, 5'd0);
    chk("v033_mis1", {31'd0, misalign_Out}, 32'd1);
    chk("v033_fa1", fault_addr_Out, 32'h22);
    cyc(1, 0, 1, 1, 0, 0, 0, 32'h31, 32'h0, 5'd3);
    chk("v033_fa2", fault_addr_Out, 32'h22);
    chk("v033_rw2", {31'd0, RegWrite_Out}, 32'd0);
    cyc(1, 0, 1, 1, 0, 0, 0, 32'h20, 32'h0, 5'd3);
    chk("v033_nowrite", ReadData_Out, saved);

    // address wrap
    cyc(0, 1, 0, 0, 0, 0, 0, 32'h400, 32'hA5A5A5A5, 5'd0);
    cyc(1, 0, 1, 1, 0, 0, 0, 32'h000, 32'h0, 5'd2);
    chk("v034_wrap", ReadData_Out, 32'hA5A5A5A5);

    // reset during a stalled store
    saved = m_mem[16];
    cyc(0, 1, 1, 0, 1, 0, 0, 32'h40, 32'h77777777, 5'd4);
    cyc(0, 1, 1, 0, 1, 0, 1, 32'h40, 32'h77777777, 5'd4);
    chk("v035_alu", ALUResult_Out, 32'h0);
    chk("v035_rdata", ReadData_Out, 32'h0);
    chk("v035_mis", {31'd0, misalign_Out}, 32'd0);
    cyc(1, 0, 1, 1, 0, 0, 0, 32'h40, 32'h0, 5'd4);
    chk("v035_notwritten", ReadData_Out, saved);

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      logic [31:0] a;
      a = {22'd0, $urandom_range(1023, 0)} & 32'h3FC;
      if ($urandom_range(5, 0) == 0) a = a | 32'($urandom_range(3, 1));
      if ($urandom_range(7, 0) == 0) a = a | 32'h0000_1000;
      cyc(1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)),
          1'($urandom_range(1, 0)), $urandom_range(4, 0) == 0, $urandom_range(7, 0) == 0,
          $urandom_range(49, 0) == 0, a, $urandom, 5'($urandom_range(31, 0)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
